// File: rtl/uncrop_filter.sv
// rtl/uncrop_filter.sv - re-embeds a patch pixel stream into a full FILL_VALUE frame; macro UNCROP_TLAST_EN adds TLAST ports
module uncrop_filter #(
  parameter int PIXEL_BIT_WIDTH  = 16,
  parameter int IN_ROWS          = 100,
  parameter int IN_COLS          = 160,
  parameter int OUT_ROWS         = 48,
  parameter int OUT_COLS         = 48,
  parameter int IMG_ROW_BITWIDTH = 10,
  parameter int IMG_COL_BITWIDTH = 10,
  parameter logic [PIXEL_BIT_WIDTH-1:0] FILL_VALUE = '0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [PIXEL_BIT_WIDTH-1:0]  pixel_in_TDATA,
  input  logic                        pixel_in_TVALID,
  output logic                        pixel_in_TREADY,
`ifdef UNCROP_TLAST_EN
  input  logic                        pixel_in_TLAST,
`endif
  input  logic [IMG_ROW_BITWIDTH-1:0] crop_Y1_TDATA,
  input  logic                        crop_Y1_TVALID,
  output logic                        crop_Y1_TREADY,
  input  logic [IMG_COL_BITWIDTH-1:0] crop_X1_TDATA,
  input  logic                        crop_X1_TVALID,
  output logic                        crop_X1_TREADY,
  output logic [PIXEL_BIT_WIDTH-1:0]  pixel_out_TDATA,
  output logic                        pixel_out_TVALID,
`ifdef UNCROP_TLAST_EN
  output logic                        pixel_out_TLAST,
  output logic                        err_tlast,
`endif
  input  logic                        pixel_out_TREADY
);

  localparam int RW = IMG_ROW_BITWIDTH;
  localparam int CW = IMG_COL_BITWIDTH;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STREAM = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  // Largest origins that still keep the whole patch inside the frame
  localparam logic [RW-1:0] Y1_MAX  = RW'(IN_ROWS - OUT_ROWS);
  localparam logic [CW-1:0] X1_MAX  = CW'(IN_COLS - OUT_COLS);
  localparam logic [RW-1:0] R_LAST  = RW'(IN_ROWS - 1);
  localparam logic [CW-1:0] C_LAST  = CW'(IN_COLS - 1);
  localparam logic [RW:0]   PATCH_R = (RW+1)'(OUT_ROWS);
  localparam logic [CW:0]   PATCH_C = (CW+1)'(OUT_COLS);

  logic [1:0]    state;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [RW-1:0] y1;
  logic [CW-1:0] x1;
  logic          y_cap;
  logic          x_cap;

  logic [RW:0]   y_end;
  logic [CW:0]   x_end;
  logic          in_win;
  logic          load_ok;
  logic          y_hs;
  logic          x_hs;
  logic          advance;
  logic          at_end;

  // Window decode, handshake readies and the "emit one beat now" decision
  always_comb begin
    y_end   = {1'b0, y1} + PATCH_R;
    x_end   = {1'b0, x1} + PATCH_C;
    in_win  = (row >= y1) && ({1'b0, row} < y_end) &&
              (col >= x1) && ({1'b0, col} < x_end);
    load_ok = !pixel_out_TVALID || pixel_out_TREADY;
    at_end  = (row == R_LAST) && (col == C_LAST);

    crop_Y1_TREADY  = !reset && (state == S_IDLE) && !y_cap;
    crop_X1_TREADY  = !reset && (state == S_IDLE) && !x_cap;
    pixel_in_TREADY = !reset && (state == S_STREAM) && in_win && load_ok;

    y_hs    = crop_Y1_TVALID && crop_Y1_TREADY;
    x_hs    = crop_X1_TVALID && crop_X1_TREADY;
    advance = (state == S_STREAM) && load_ok && (in_win ? pixel_in_TVALID : 1'b1);
  end

  // Origin capture, raster walk and frame sequencing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
      y1    <= '0;
      x1    <= '0;
      y_cap <= 1'b0;
      x_cap <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (y_hs) begin
            y1    <= (crop_Y1_TDATA > Y1_MAX) ? Y1_MAX : crop_Y1_TDATA;
            y_cap <= 1'b1;
          end
          if (x_hs) begin
            x1    <= (crop_X1_TDATA > X1_MAX) ? X1_MAX : crop_X1_TDATA;
            x_cap <= 1'b1;
          end
          if ((y_cap || y_hs) && (x_cap || x_hs)) begin
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (advance) begin
            if (at_end) begin
              state <= S_DONE;
            end else if (col == C_LAST) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DONE: begin
          // Leave only once the last beat has drained, so a new origin cannot race it
          if (load_ok) begin
            y_cap <= 1'b0;
            x_cap <= 1'b0;
            row   <= '0;
            col   <= '0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output register: patch pixel inside the window, fill value outside
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_out_TVALID <= 1'b0;
      pixel_out_TDATA  <= '0;
    end else if (advance) begin
      pixel_out_TDATA  <= in_win ? pixel_in_TDATA : FILL_VALUE;
      pixel_out_TVALID <= 1'b1;
    end else if (load_ok) begin
      pixel_out_TVALID <= 1'b0;
    end
  end

`ifdef UNCROP_TLAST_EN
  logic last_patch;

  // Final patch position is the bottom-right corner of the window
  always_comb begin
    last_patch = ({1'b0, row} == (y_end - 1'b1)) && ({1'b0, col} == (x_end - 1'b1));
  end

  // TLAST travels with the frame's final beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_out_TLAST <= 1'b0;
    end else if (advance) begin
      pixel_out_TLAST <= at_end;
    end
  end

  // Sticky flag when the patch source does not mark its final beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_tlast <= 1'b0;
    end else if (pixel_in_TVALID && pixel_in_TREADY && last_patch && !pixel_in_TLAST) begin
      err_tlast <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/uncrop_filter.md
Name: uncrop_filter

Overview:
- Inverse of crop_filter: accepts an OUT_ROWS x OUT_COLS patch pixel stream and the crop origin (Y1, X1) on AXI-stream-style ports.
- Emits a full IN_ROWS x IN_COLS raster frame with the patch placed at (Y1, X1) and FILL_VALUE everywhere else.
- Sits after the crop and Gaussian processing path, re-embedding the processed patch into frame coordinates for display and comparison.

Parameters:
- PIXEL_BIT_WIDTH, 16, pixel word width.
- IN_ROWS, 100, full-frame rows.
- IN_COLS, 160, full-frame columns.
- OUT_ROWS, 48, patch rows.
- OUT_COLS, 48, patch columns.
- IMG_ROW_BITWIDTH, 10, row coordinate/counter width.
- IMG_COL_BITWIDTH, 10, column coordinate/counter width.
- FILL_VALUE, 0, pixel value emitted outside the patch.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pixel_in_TDATA  in  PIXEL_BIT_WIDTH  patch pixel, raster order
- pixel_in_TVALID  in  1  patch pixel valid
- pixel_in_TREADY  out  1  patch pixel accepted when high with TVALID
- crop_Y1_TDATA  in  IMG_ROW_BITWIDTH  patch top row
- crop_Y1_TVALID  in  1
- crop_Y1_TREADY  out  1
- crop_X1_TDATA  in  IMG_COL_BITWIDTH  patch left column
- crop_X1_TVALID  in  1
- crop_X1_TREADY  out  1
- pixel_out_TDATA  out  PIXEL_BIT_WIDTH  frame pixel, raster order
- pixel_out_TVALID  out  1
- pixel_out_TREADY  in  1

Behaviour:
- Reset (async, active-high): state=IDLE; row/col counters=0; Y1/X1 captured flags=0; pixel_out_TVALID=0; pixel_out_TDATA=0; all TREADYs=0 while reset is asserted.
- Transfer occurs on a rising clk edge when TVALID&TREADY. Outputs are registered. pixel_out_TVALID, once high, holds it and TDATA stable until TREADY.
- IDLE:
  - crop_Y1_TREADY = !y_captured; crop_X1_TREADY = !x_captured.
  - Y1 and X1 are captured independently, in either order or in the same cycle.
  - When both are captured, go to STREAM next cycle.
  - pixel_in_TREADY=0.
- Clamping at capture: Y1 > IN_ROWS-OUT_ROWS stores IN_ROWS-OUT_ROWS; X1 > IN_COLS-OUT_COLS stores IN_COLS-OUT_COLS.
- STREAM:
  - Counters (r,c) walk the frame in raster order, c fastest.
  - load_ok = !pixel_out_TVALID | pixel_out_TREADY.
  - in_win = (Y1<=r<Y1+OUT_ROWS) & (X1<=c<X1+OUT_COLS).
  - When in_win: pixel_in_TREADY=load_ok. On a pixel_in handshake, the output register takes pixel_in_TDATA, TVALID goes to 1, and (r,c) advances.
  - When !in_win: pixel_in_TREADY=0. If load_ok, the output register takes FILL_VALUE, TVALID goes to 1, and (r,c) advances.
  - If load_ok and no new pixel is produced, TVALID drops to 0.
  - Latency: one cycle from pixel_in handshake to pixel_out_TVALID.
- Wrap: c==IN_COLS-1 -> c=0, r++. Advance past (IN_ROWS-1, IN_COLS-1) -> state DONE.
- DONE: waits until the final output beat is accepted (or pixel_out_TVALID==0), then clears the captured flags, zeroes the counters, and returns to IDLE for the next frame. Coordinates are never reused across frames.
- Patch pixel count per frame is exactly OUT_ROWS*OUT_COLS. Extra pixel_in beats are not accepted outside STREAM in_win (backpressure only, no drop).
- Reset mid-frame: immediate return to IDLE. A partially emitted frame is abandoned and the next frame starts at (0,0).

Optional Feature:
- Macro UNCROP_TLAST_EN.
- Defined: adds output port pixel_out_TLAST (1 bit, registered with TDATA, reset 0), high on the beat for (IN_ROWS-1, IN_COLS-1) only. Also adds pixel_in_TLAST input, which is checked on the final patch beat; a mismatch sets a sticky output err_tlast (reset 0, cleared only by reset).
- Undefined: none of these ports exist; behaviour is otherwise identical.

Test Plan:
- Y1=37, X1=59, patch value=index, FILL_VALUE=0, TREADY always 1 -> 16000 output beats. Beat 37*160+59=5979 equals 0; beat 5979+47=6026 equals 47; beat 38*160+59=6139 equals 48; beat 5978 equals 0; final patch beat 84*160+106=13546 equals 2303.
- Y1=0, X1=0 and Y1=52, X1=112 (corners) -> first beat = patch[0]; for the second origin, last beat (index 15999) = patch[2303].
- Y1=90, X1=150 -> clamped to (52, 112); output identical to the previous corner case.
- Random TVALID/TREADY on all four inputs (50% each) with Y1=37, X1=59 -> output sequence identical to the first scenario; TDATA stable while TVALID&!TREADY.
- X1 sent 10 cycles before Y1 -> no pixel_in_TREADY until both are captured. Two back-to-back frames with different origins -> both frames correct.
- Reset asserted asynchronously at output beat 7000 -> pixel_out_TVALID=0 immediately. Next frame with Y1=0, X1=0 -> beat 0 = patch[0].
